uart_fifo_mmio: RTL and testbench

Parametrised, memory-mapped byte-buffering peripheral that replaces the fixed 13-entry UART buffers with true circular FIFOs, one for RX and one for TX. Each FIFO has its own read and write pointers, occupancy counts, full/empty status, sticky overflow flags, flush control and an interrupt output. The block sits between the CPU data bus (after external address decode) and the byte-level UART receiver and emitter.

---
 rtl/uart_fifo_mmio.sv | 128 ++++++++++++
 tb/tb_uart_fifo_mmio.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_mmio.sv
// rtl/uart_fifo_mmio.sv - memory-mapped RX/TX circular byte FIFOs between the CPU bus and a UART
module uart_fifo_mmio #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [1:0]  mem_addr,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] mem_wdata,
    output logic [31:0] read_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [RX_AW-1:0] r_rx_wr, r_rx_rd;
    logic [TX_AW-1:0] r_tx_wr, r_tx_rd;
    logic [RX_AW:0]   r_rx_cnt;
    logic [TX_AW:0]   r_tx_cnt;
    logic             r_rx_ovf, r_tx_ovf, r_rx_ie, r_tx_ie, r_irq;

    logic w_wr, w_rd, w_data_wr, w_ctl_wr;
    logic w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic w_rx_push, w_rx_pop, w_rx_drop, w_tx_push, w_tx_pop, w_tx_drop;
    logic [7:0] w_rx_cnt8, w_tx_cnt8;
    logic w_unused;

    assign w_wr      = sel && mem_write;
    assign w_rd      = sel && mem_read;
    assign w_data_wr = w_wr && (mem_addr == 2'd0);
    assign w_ctl_wr  = w_wr && (mem_addr == 2'd2);

    assign w_rx_full  = (r_rx_cnt == RX_FULL_CNT);
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == TX_FULL_CNT);
    assign w_tx_empty = (r_tx_cnt == '0);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept a push.
    assign w_rx_pop  = w_rd && (mem_addr == 2'd0) && !w_rx_empty;
    assign w_rx_push = rx_valid && (!w_rx_full || w_rx_pop);
    assign w_rx_drop = rx_valid && w_rx_full && !w_rx_pop;
    assign w_tx_pop  = tx_valid && tx_ready;
    assign w_tx_push = w_data_wr && (!w_tx_full || w_tx_pop);
    assign w_tx_drop = w_data_wr && w_tx_full && !w_tx_pop;

    assign tx_valid = !w_tx_empty;
    assign tx_data  = r_tx_mem[r_tx_rd];
    assign irq      = r_irq;

    assign w_rx_cnt8 = 8'(r_rx_cnt);
    assign w_tx_cnt8 = 8'(r_tx_cnt);
    assign w_unused  = ^mem_wdata[31:8];

    always_comb begin
        read_data = 32'd0;
        case (mem_addr)
            2'd0: read_data = w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rd]};
            2'd1: read_data = {8'd0, w_tx_cnt8, w_rx_cnt8, 2'b00, r_tx_ovf, r_rx_ovf,
                               w_tx_full, w_tx_empty, w_rx_full, !w_rx_empty};
            2'd2: read_data = {26'd0, r_tx_ie, r_rx_ie, 4'b0000};
            default: read_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data;
        if (w_tx_push) r_tx_mem[r_tx_wr] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst || (w_ctl_wr && mem_wdata[0])) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (w_ctl_wr && mem_wdata[1])) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
        end
    end

    // Overflow set takes priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ovf <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_rx_ie  <= 1'b0;
            r_tx_ie  <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_rx_drop)                     r_rx_ovf <= 1'b1;
            else if (w_ctl_wr && mem_wdata[2]) r_rx_ovf <= 1'b0;
            if (w_tx_drop)                     r_tx_ovf <= 1'b1;
            else if (w_ctl_wr && mem_wdata[3]) r_tx_ovf <= 1'b0;
            if (w_ctl_wr) begin
                r_rx_ie <= mem_wdata[4];
                r_tx_ie <= mem_wdata[5];
            end
            r_irq <= (r_rx_ie && !w_rx_empty) || (r_tx_ie && w_tx_empty);
        end
    end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// tb/tb_uart_fifo_mmio.sv - directed self-checking bench for uart_fifo_mmio
module tb_uart_fifo_mmio;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [1:0]  mem_addr = 2'd0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] read_data;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] v;

    uart_fifo_mmio #(.RX_DEPTH(16), .TX_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .sel(sel), .mem_addr(mem_addr),
        .mem_write(mem_write), .mem_read(mem_read), .mem_wdata(mem_wdata),
        .read_data(read_data), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One bus/receiver cycle, driven from a falling edge; rdv is sampled before the rising edge.
    task automatic bus_cycle(input logic rd, input logic wr, input logic [1:0] a,
                             input logic [31:0] wd, input logic rxv, input logic [7:0] rxd,
                             output logic [31:0] rdv);
        sel = rd | wr;
        mem_read = rd;
        mem_write = wr;
        mem_addr = a;
        mem_wdata = wd;
        rx_valid = rxv;
        rx_data = rxd;
        #1 rdv = read_data;
        tick();
        sel = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] rdv);
        bus_cycle(1'b1, 1'b0, a, 32'd0, 1'b0, 8'd0, rdv);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] d;
        bus_cycle(1'b0, 1'b1, a, wd, 1'b0, 8'd0, d);
    endtask

    task automatic rx_push(input logic [7:0] b);
        logic [31:0] d;
        bus_cycle(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, b, d);
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] rdv);
        mem_addr = a;
        #1 rdv = read_data;
    endtask

    initial begin
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();
        peek(2'd1, v);  check("reset_status", v, 32'h0000_0004);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);

        rx_push(8'h41); rx_push(8'h42); rx_push(8'h43);
        peek(2'd1, v);  check("rx3_status", v, 32'h0000_0305);
        bus_rd(2'd0, v); check("rx_rd0", v, 32'h41);
        bus_rd(2'd0, v); check("rx_rd1", v, 32'h42);
        bus_rd(2'd0, v); check("rx_rd2", v, 32'h43);
        bus_rd(2'd0, v); check("rx_rd_empty", v, 32'h0);
        peek(2'd1, v);  check("rx_empty_bit0", v & 32'h1, 32'h0);

        for (int i = 0; i < 17; i++) rx_push(8'(8'h10 + i));
        peek(2'd1, v);  check("rx_full_ovf", v, 32'h0000_1017);
        bus_cycle(1'b0, 1'b1, 2'd2, 32'h04, 1'b1, 8'h99, v);
        peek(2'd1, v);  check("ovf_set_wins", v, 32'h0000_1017);
        bus_wr(2'd2, 32'h04);
        peek(2'd1, v);  check("ovf_clear", v, 32'h0000_1007);
        bus_cycle(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 8'hEE, v);
        check("full_pushpop_rd", v, 32'h10);
        peek(2'd1, v);  check("full_pushpop_status", v, 32'h0000_1007);
        for (int i = 0; i < 15; i++) begin
            bus_rd(2'd0, v);
            check("rx_wrap_order", v, 32'(8'h11 + i));
        end
        bus_rd(2'd0, v); check("rx_wrap_last", v, 32'hEE);
        peek(2'd1, v);  check("rx_drained", v, 32'h0000_0004);

        bus_wr(2'd0, 32'h55); bus_wr(2'd0, 32'hAA);
        tick(); tick();
        check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
        check("tx_hold_data", {24'd0, tx_data}, 32'h55);
        peek(2'd1, v);  check("tx2_status", v, 32'h0002_0000);
        tx_ready = 1'b1;
        #1 check("tx_emit0", {24'd0, tx_data}, 32'h55);
        tick();
        check("tx_emit1", {24'd0, tx_data}, 32'hAA);
        tick();
        tx_ready = 1'b0;
        check("tx_done_valid", {31'd0, tx_valid}, 32'd0);
        peek(2'd1, v);  check("tx_done_status", v, 32'h0000_0004);

        bus_wr(2'd2, 32'h10);
        tick();
        check("irq_ie_empty", {31'd0, irq}, 32'd0);
        rx_push(8'h5A);
        check("irq_lag", {31'd0, irq}, 32'd0);
        tick();
        check("irq_set", {31'd0, irq}, 32'd1);
        bus_cycle(1'b0, 1'b1, 2'd2, 32'h11, 1'b1, 8'h66, v);
        peek(2'd1, v);  check("flush_vs_push", v, 32'h0000_0004);
        check("irq_before_drop", {31'd0, irq}, 32'd1);
        tick();
        check("irq_clear", {31'd0, irq}, 32'd0);
        peek(2'd2, v);  check("ctl_readback", v, 32'h10);

        for (int i = 0; i < 17; i++) bus_wr(2'd0, 32'(8'h60 + i));
        peek(2'd1, v);  check("tx_full_ovf", v, 32'h0010_0028);
        check("tx_full_head", {24'd0, tx_data}, 32'h60);
        bus_wr(2'd2, 32'h3A);
        peek(2'd1, v);  check("tx_flush_status", v, 32'h0000_0004);
        check("tx_flush_valid", {31'd0, tx_valid}, 32'd0);
        peek(2'd2, v);  check("ctl_both_ie", v, 32'h30);

        bus_wr(2'd0, 32'h77); bus_wr(2'd0, 32'h78);
        rx_push(8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        peek(2'd1, v);  check("rst_status", v, 32'h0000_0004);
        peek(2'd2, v);  check("rst_ctl", v, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        tick();
        check("rst_irq_after", {31'd0, irq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
